// File: rtl/pixel_config_readback_pkg.sv
// Shared types and packed-slot layout for the MIC4 pixel-configuration readback path.
package pixel_config_readback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int SLOT_W    = 16;
    localparam int VALID_POS = 15;

    // One 16-bit half of DOUT: valid flag on top, zero-extended pixel word below.
    function automatic logic [SLOT_W-1:0] make_slot(input logic valid,
                                                    input logic [VALID_POS-1:0] word);
        logic [SLOT_W-1:0] s;
        s = '0;
        s[VALID_POS]     = valid;
        s[VALID_POS-1:0] = word;
        return s;
    endfunction

endpackage

// File: rtl/pixel_config_readback_if.sv
// Packed-word output channel. DOUT/DOUT_VALID hold until DOUT_VALID & DOUT_READY;
// the transfer happens on that clock edge, and a new word may load in the same cycle.
interface pixel_config_readback_if;
    logic [31:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;

    modport master (output DOUT, output DOUT_VALID, input DOUT_READY);
    modport slave  (input DOUT, input DOUT_VALID, output DOUT_READY);
endinterface

// File: rtl/pixel_config_readback_serial_edge_sync.sv
// Synchronizes the asynchronous serial clock/data pair and turns the synced clock's
// rising edge into a one-cycle strobe with the matching data bit.
module serial_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_clk,
    input  logic s_data,
    output logic strobe,
    output logic bit_out
);

    logic [SYNC_STAGES-1:0] clk_sh;
    logic [SYNC_STAGES-1:0] data_sh;
    logic                   clk_prev;

    // Equal-depth chains keep data aligned with the clock edge it was sampled on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sh   <= '0;
            data_sh  <= '0;
            clk_prev <= 1'b0;
            strobe   <= 1'b0;
            bit_out  <= 1'b0;
        end else begin
            clk_sh   <= {clk_sh[SYNC_STAGES-2:0], s_clk};
            data_sh  <= {data_sh[SYNC_STAGES-2:0], s_data};
            clk_prev <= clk_sh[SYNC_STAGES-1];
            strobe   <= clk_sh[SYNC_STAGES-1] & ~clk_prev;
            bit_out  <= data_sh[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/pixel_config_readback.sv
// Receive side of the MIC4 pixel-config serial link: rebuilds pixel words, packs two
// per 32-bit word and offers them on a valid/ready channel with sticky error flags.
module pixel_config_readback
    import pixel_config_readback_pkg::*;
#(
    parameter int DATA_WIDTH      = 15,
    parameter int SHIFT_DIRECTION = 1,
    parameter int CNT_WIDTH       = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int WCNT_WIDTH      = 16
) (
    input  logic                  SYS_CLK,
    input  logic                  RESET_N,
    input  logic                  ENABLE,
    input  logic                  S_CLK_IN,
    input  logic                  S_DATA_IN,
    pixel_config_readback_if.master dout_if,
    output logic [WCNT_WIDTH-1:0] WORD_CNT,
    output logic                  OVERFLOW,
    output logic                  PARTIAL,
    output logic                  BUSY,
    output state_t                STATE
);

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   sr, sr_nxt, sr_shift;
    logic [DATA_WIDTH-1:0]   slot0, slot0_nxt;
    logic [CNT_WIDTH-1:0]    bit_cnt, bit_cnt_nxt;
    logic                    half, half_nxt;
    logic [31:0]             dout, dout_nxt;
    logic                    dout_valid, dout_valid_nxt;
    logic [WCNT_WIDTH-1:0]   word_cnt, word_cnt_nxt;
    logic                    overflow, overflow_nxt;
    logic                    partial, partial_nxt;
    logic                    strobe, bit_in;
    logic                    pack_load;
    logic [31:0]             pack_word;

    serial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (SYS_CLK),
        .rst_n  (RESET_N),
        .s_clk  (S_CLK_IN),
        .s_data (S_DATA_IN),
        .strobe (strobe),
        .bit_out(bit_in)
    );

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            sr         <= '0;
            slot0      <= '0;
            bit_cnt    <= '0;
            half       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
            partial    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            slot0      <= slot0_nxt;
            bit_cnt    <= bit_cnt_nxt;
            half       <= half_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            word_cnt   <= word_cnt_nxt;
            overflow   <= overflow_nxt;
            partial    <= partial_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        slot0_nxt      = slot0;
        bit_cnt_nxt    = bit_cnt;
        half_nxt       = half;
        dout_nxt       = dout;
        dout_valid_nxt = dout_valid;
        word_cnt_nxt   = word_cnt;
        overflow_nxt   = overflow;
        partial_nxt    = partial;
        pack_load      = 1'b0;
        pack_word      = '0;

        if (SHIFT_DIRECTION == 1) sr_shift = {sr[DATA_WIDTH-2:0], bit_in};
        else                      sr_shift = {bit_in, sr[DATA_WIDTH-1:1]};

        if (dout_valid && dout_if.DOUT_READY) dout_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (ENABLE) begin
                    state_nxt    = RECV;
                    bit_cnt_nxt  = '0;
                    half_nxt     = 1'b0;
                    word_cnt_nxt = '0;
                    overflow_nxt = 1'b0;
                    partial_nxt  = 1'b0;
                end
            end
            RECV: begin
                // A strobe coinciding with ENABLE falling still lands before FLUSH.
                if (strobe) begin
                    sr_nxt = sr_shift;
                    if (bit_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        bit_cnt_nxt = '0;
                        if (word_cnt != '1) word_cnt_nxt = word_cnt + 1'b1;
                        if (!half) begin
                            slot0_nxt = sr_shift;
                            half_nxt  = 1'b1;
                        end else begin
                            pack_load = 1'b1;
                            pack_word = {make_slot(1'b1, 15'(sr_shift)),
                                         make_slot(1'b1, 15'(slot0))};
                            half_nxt  = 1'b0;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                if (!ENABLE) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (bit_cnt != '0) partial_nxt = 1'b1;
                bit_cnt_nxt = '0;
                if (half) begin
                    pack_load = 1'b1;
                    pack_word = {16'h0000, make_slot(1'b1, 15'(slot0))};
                    half_nxt  = 1'b0;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // The output register is free if empty or being accepted this cycle.
        if (pack_load) begin
            if (!dout_valid || dout_if.DOUT_READY) begin
                dout_nxt       = pack_word;
                dout_valid_nxt = 1'b1;
            end else begin
                overflow_nxt = 1'b1;
            end
        end
    end

    assign dout_if.DOUT       = dout;
    assign dout_if.DOUT_VALID = dout_valid;
    assign WORD_CNT           = word_cnt;
    assign OVERFLOW           = overflow;
    assign PARTIAL            = partial;
    assign BUSY               = (state != IDLE);
    assign STATE              = state;

endmodule
